// File: rtl/lvds_rx_align_ctrl.sv
// lvds_rx_align_ctrl
//
// Word-alignment controller for the LVDS receive path (clk_sys domain). While
// train_en is high it compares captured words against TRAIN_PATTERN, requests
// single-cycle bitslips from the deserializer until the pattern is seen
// MATCH_COUNT times in a row, then locks and forwards payload words. A watchdog
// drops lock when the word stream stops; running out of bit positions latches
// align_fail until train_en is dropped.
//
// Ports
//   clk_sys        single clock, rising edge
//   reset          synchronous, active-high
//   train_en       level enable for training and the link
//   rx_data_out    captured parallel word
//   rx_data_valid  rx_data_out valid this cycle
//   bitslip        one-cycle pulse, shifts the word boundary by one bit
//   aligned        high while locked
//   align_fail     high after all bit positions were tried without lock
//   lock_lost      one-cycle pulse on watchdog timeout
//   slip_count     slips issued since training began
//   rx_data_q      registered copy of rx_data_out
//   rx_valid_q     rx_data_q holds a forwarded payload word

module lvds_rx_align_ctrl #(
    parameter int unsigned                PARALLEL_WIDTH = 8,
    parameter int unsigned                SERIAL_RATIO   = 8,
    parameter logic [PARALLEL_WIDTH-1:0]  TRAIN_PATTERN  = 8'h1E,
    parameter int unsigned                MATCH_COUNT    = 4,
    parameter int unsigned                SETTLE_WORDS   = 2,
    parameter int unsigned                TIMEOUT_CYCLES = 64
) (
    input  logic                              clk_sys,
    input  logic                              reset,
    input  logic                              train_en,
    input  logic [PARALLEL_WIDTH-1:0]         rx_data_out,
    input  logic                              rx_data_valid,
    output logic                              bitslip,
    output logic                              aligned,
    output logic                              align_fail,
    output logic                              lock_lost,
    output logic [$clog2(SERIAL_RATIO)-1:0]   slip_count,
    output logic [PARALLEL_WIDTH-1:0]         rx_data_q,
    output logic                              rx_valid_q
);

    localparam int unsigned SlipW   = $clog2(SERIAL_RATIO);
    localparam int unsigned MatchW  = $clog2(MATCH_COUNT + 1);
    localparam int unsigned SettleW = (SETTLE_WORDS > 0) ? $clog2(SETTLE_WORDS + 1) : 1;
    localparam int unsigned WdW     = $clog2(TIMEOUT_CYCLES + 1);

    // "Last" values: the counter value at which the current event completes the count.
    localparam logic [SlipW-1:0]   SlipLast   = SlipW'(SERIAL_RATIO - 1);
    localparam logic [MatchW-1:0]  MatchLast  = MatchW'(MATCH_COUNT - 1);
    localparam logic [SettleW-1:0] SettleLast = SettleW'((SETTLE_WORDS > 0) ? SETTLE_WORDS - 1 : 0);
    localparam logic [WdW-1:0]     WdLast     = WdW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StCheck,
        StSlip,
        StSettle,
        StLocked,
        StFail
    } state_e;

    state_e                      state_q;
    logic [SlipW-1:0]            slip_cnt_q;
    logic [MatchW-1:0]           match_cnt_q;
    logic [SettleW-1:0]          settle_cnt_q;
    logic [WdW-1:0]              wd_cnt_q;
    logic                        bitslip_q;
    logic                        aligned_q;
    logic                        align_fail_q;
    logic                        lock_lost_q;
    logic [PARALLEL_WIDTH-1:0]   data_q;
    logic                        valid_q;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q      <= StIdle;
            slip_cnt_q   <= '0;
            match_cnt_q  <= '0;
            settle_cnt_q <= '0;
            wd_cnt_q     <= '0;
            bitslip_q    <= 1'b0;
            aligned_q    <= 1'b0;
            align_fail_q <= 1'b0;
            lock_lost_q  <= 1'b0;
            data_q       <= '0;
            valid_q      <= 1'b0;
        end else begin
            // The data register samples every cycle; only rx_valid_q qualifies it.
            data_q      <= rx_data_out;
            bitslip_q   <= 1'b0;
            lock_lost_q <= 1'b0;
            valid_q     <= 1'b0;

            if (!train_en) begin
                // Drops any pending slip as well: StSlip is simply abandoned.
                state_q      <= StIdle;
                slip_cnt_q   <= '0;
                match_cnt_q  <= '0;
                settle_cnt_q <= '0;
                wd_cnt_q     <= '0;
                aligned_q    <= 1'b0;
                align_fail_q <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        slip_cnt_q   <= '0;
                        match_cnt_q  <= '0;
                        settle_cnt_q <= '0;
                        wd_cnt_q     <= '0;
                        state_q      <= StCheck;
                    end

                    StCheck: begin
                        if (rx_data_valid) begin
                            if (rx_data_out == TRAIN_PATTERN) begin
                                match_cnt_q <= match_cnt_q + 1'b1;
                                if (match_cnt_q == MatchLast) begin
                                    // The completing word is not forwarded.
                                    state_q   <= StLocked;
                                    aligned_q <= 1'b1;
                                    wd_cnt_q  <= '0;
                                end
                            end else begin
                                match_cnt_q <= '0;
                                if (slip_cnt_q == SlipLast) begin
                                    // Every boundary tried; no further slip is issued.
                                    state_q      <= StFail;
                                    align_fail_q <= 1'b1;
                                end else begin
                                    state_q <= StSlip;
                                end
                            end
                        end
                    end

                    StSlip: begin
                        bitslip_q    <= 1'b1;
                        slip_cnt_q   <= slip_cnt_q + 1'b1;
                        settle_cnt_q <= '0;
                        match_cnt_q  <= '0;
                        state_q      <= (SETTLE_WORDS == 0) ? StCheck : StSettle;
                    end

                    StSettle: begin
                        // Words straddling the boundary change are discarded.
                        if (rx_data_valid) begin
                            settle_cnt_q <= settle_cnt_q + 1'b1;
                            if (settle_cnt_q == SettleLast) begin
                                state_q     <= StCheck;
                                match_cnt_q <= '0;
                            end
                        end
                    end

                    StLocked: begin
                        if (rx_data_valid) begin
                            wd_cnt_q <= '0;
                            valid_q  <= 1'b1;
                        end else if (wd_cnt_q == WdLast) begin
                            lock_lost_q <= 1'b1;
                            aligned_q   <= 1'b0;
                            slip_cnt_q  <= '0;
                            match_cnt_q <= '0;
                            wd_cnt_q    <= '0;
                            state_q     <= StCheck;
                        end else begin
                            wd_cnt_q <= wd_cnt_q + 1'b1;
                        end
                    end

                    StFail: begin
                        // Sticky until train_en drops or reset.
                        align_fail_q <= 1'b1;
                    end

                    default: begin
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

    assign bitslip    = bitslip_q;
    assign aligned    = aligned_q;
    assign align_fail = align_fail_q;
    assign lock_lost  = lock_lost_q;
    assign slip_count = slip_cnt_q;
    assign rx_data_q  = data_q;
    assign rx_valid_q = valid_q;

endmodule

// File: tb/tb_lvds_rx_align_ctrl.sv
// Bench for lvds_rx_align_ctrl: a bit-rotating deserializer model feeds the DUT,
// a behavioural model predicts every output every cycle, and a few literal
// checks pin the model at the scenario boundaries.

module tb_lvds_rx_align_ctrl;

    localparam logic [7:0]  Pat     = 8'h1E;
    localparam int          Sr      = 8;
    localparam int          Mc      = 4;
    localparam int          Settle  = 2;
    localparam int          Timeout = 64;

    logic       clk_sys = 1'b0;
    logic       reset;
    logic       train_en;
    logic [7:0] rx_data_out;
    logic       rx_data_valid;
    logic       bitslip;
    logic       aligned;
    logic       align_fail;
    logic       lock_lost;
    logic [2:0] slip_count;
    logic [7:0] rx_data_q;
    logic       rx_valid_q;

    always #5 clk_sys = ~clk_sys;

    lvds_rx_align_ctrl dut (
        .clk_sys       (clk_sys),
        .reset         (reset),
        .train_en      (train_en),
        .rx_data_out   (rx_data_out),
        .rx_data_valid (rx_data_valid),
        .bitslip       (bitslip),
        .aligned       (aligned),
        .align_fail    (align_fail),
        .lock_lost     (lock_lost),
        .slip_count    (slip_count),
        .rx_data_q     (rx_data_q),
        .rx_valid_q    (rx_valid_q)
    );

    // Model: progress of training expressed as flags and remaining-work counts.
    bit         m_active, m_pending, m_locked, m_failed;
    int         m_slips, m_matches, m_discard, m_gap;
    bit         e_bitslip, e_lost, e_valid;
    logic [7:0] e_data;

    int rot;       // deserializer boundary offset; 0 = aligned
    int n_vec, n_err, n_pulses, n_lost, cyc;

    function automatic logic [7:0] rotl(input logic [7:0] w, input int k);
        logic [15:0] d;
        d = {w, w} << (k % 8);
        return d[15:8];
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        if (got !== want) begin
            $display("FAIL %s @cycle %0d: got %0h, want %0h", name, cyc, got, want);
            n_err++;
        end
    endtask

    task automatic model_step();
        e_bitslip = 0;
        e_lost    = 0;
        e_valid   = 0;
        e_data    = reset ? 8'h00 : rx_data_out;
        if (reset || !train_en) begin
            m_active = 0; m_pending = 0; m_locked = 0; m_failed = 0;
            m_slips = 0; m_matches = 0; m_discard = 0; m_gap = 0;
        end else if (!m_active) begin
            m_active = 1;
        end else if (m_pending) begin
            m_pending = 0;
            e_bitslip = 1;
            m_slips++;
            m_discard = Settle;
        end else if (m_locked) begin
            if (rx_data_valid) begin
                m_gap   = 0;
                e_valid = 1;
            end else begin
                m_gap++;
                if (m_gap == Timeout) begin
                    e_lost = 1; m_locked = 0; m_slips = 0; m_matches = 0; m_gap = 0;
                end
            end
        end else if (m_failed) begin
            m_failed = 1;
        end else if (m_discard > 0) begin
            if (rx_data_valid) m_discard--;
        end else if (rx_data_valid) begin
            if (rx_data_out == Pat) begin
                m_matches++;
                if (m_matches == Mc) begin
                    m_locked = 1;
                    m_gap    = 0;
                end
            end else begin
                m_matches = 0;
                if (m_slips == Sr - 1) m_failed = 1;
                else m_pending = 1;
            end
        end
    endtask

    task automatic compare();
        chk("bitslip", bitslip, e_bitslip);
        chk("aligned", aligned, m_locked);
        chk("align_fail", align_fail, m_failed);
        chk("lock_lost", lock_lost, e_lost);
        chk("slip_count", slip_count, m_slips);
        chk("rx_valid_q", rx_valid_q, e_valid);
        chk("rx_data_q", rx_data_q, e_data);
    endtask

    // One clock: drive, let the edge happen, predict, compare, then apply any slip.
    task automatic cycle(input bit v, input logic [7:0] w);
        rx_data_valid = v;
        rx_data_out   = v ? rotl(w, rot) : 8'($urandom);
        @(posedge clk_sys);
        model_step();
        #1;
        cyc++;
        n_vec++;
        compare();
        if (bitslip === 1'b1) n_pulses++;
        if (lock_lost === 1'b1) n_lost++;
        if (e_bitslip) rot = (rot + 7) % 8;
    endtask

    task automatic restart(input int new_rot);
        train_en = 1'b0;
        cycle(0, 8'h00);
        train_en = 1'b1;
        rot      = new_rot;
        n_pulses = 0;
        n_lost   = 0;
    endtask

    task automatic lock_up(input string name);
        int i;
        for (i = 0; i < 600 && aligned !== 1'b1; i++) begin
            if ($urandom_range(0, 2) == 0) cycle(1, Pat);
            else cycle(0, 8'h00);
        end
        if (aligned !== 1'b1) begin
            $display("FAIL %s: no lock within budget, aligned=%b want 1", name, aligned);
            n_err++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: bench did not finish, want finish");
        $fatal(1);
    end

    initial begin
        int i;
        int vprob;
        n_vec = 0; n_err = 0; n_pulses = 0; n_lost = 0; cyc = 0; rot = 0;
        reset = 1'b1; train_en = 1'b0; rx_data_valid = 1'b0; rx_data_out = 8'h00;

        // Reset state.
        repeat (3) cycle(1, 8'hFF);
        chk("rst_aligned", aligned, 0);
        chk("rst_slip_count", slip_count, 0);
        chk("rst_rx_data_q", rx_data_q, 8'h00);
        chk("rst_rx_valid_q", rx_valid_q, 0);

        // Aligned from the start: one training word every 8 cycles.
        reset = 1'b0; train_en = 1'b1; n_pulses = 0;
        for (int k = 0; k < 4; k++) begin
            repeat (7) cycle(0, 8'h00);
            cycle(1, Pat);
        end
        chk("start_aligned", aligned, 1);
        chk("start_slip_count", slip_count, 0);
        chk("start_pulses", n_pulses, 0);
        cycle(1, 8'h3C);
        chk("payload_valid", rx_valid_q, 1);
        chk("payload_data", rx_data_q, 8'h3C);
        cycle(1, Pat);
        chk("pattern_forwarded", rx_valid_q, 1);
        for (int k = 0; k < 20; k++) begin
            repeat ($urandom_range(0, 10)) cycle(0, 8'h00);
            cycle(1, 8'($urandom));
        end

        // Watchdog: 63 idle cycles keep lock, 64 drop it.
        cycle(1, 8'h55);
        repeat (63) cycle(0, 8'h00);
        cycle(1, 8'hA5);
        chk("wd63_aligned", aligned, 1);
        chk("wd63_lost", n_lost, 0);
        repeat (63) cycle(0, 8'h00);
        chk("wd_pre_lost", n_lost, 0);
        cycle(0, 8'h00);
        chk("wd_lock_lost", lock_lost, 1);
        chk("wd_aligned", aligned, 0);
        chk("wd_slip_count", slip_count, 0);
        cycle(0, 8'h00);
        chk("wd_pulse_width", lock_lost, 0);
        chk("wd_count", n_lost, 1);
        lock_up("relock");

        // Offset of 3 bits, with garbage on non-valid cycles.
        restart(3);
        lock_up("offset3");
        chk("off3_pulses", n_pulses, 3);
        chk("off3_slip_count", slip_count, 3);

        // Never matches: seven slips, then fail without an eighth.
        restart(0);
        for (i = 0; i < 800 && align_fail !== 1'b1; i++) cycle($urandom_range(0, 1) == 1, 8'h00);
        chk("nm_align_fail", align_fail, 1);
        chk("nm_pulses", n_pulses, 7);
        chk("nm_slip_count", slip_count, 7);
        repeat (40) cycle($urandom_range(0, 1) == 1, 8'h00);
        chk("nm_no_eighth", n_pulses, 7);
        train_en = 1'b0;
        cycle(0, 8'h00);
        chk("nm_clear_fail", align_fail, 0);
        chk("nm_clear_slips", slip_count, 0);
        train_en = 1'b1;
        cycle(1, 8'h00);
        chk("nm_restart_slips", slip_count, 0);

        // Reset while a slip is pending: no bitslip may follow.
        restart(2);
        for (i = 0; i < 50 && !m_pending; i++) cycle(1, Pat);
        reset = 1'b1;
        cycle(1, Pat);
        chk("rst_slip_bitslip", bitslip, 0);
        reset = 1'b0;
        cycle(0, 8'h00);
        chk("rst_slip_after", bitslip, 0);

        // train_en low in the middle of SETTLE.
        for (i = 0; i < 80 && m_discard == 0; i++) cycle(1, Pat);
        train_en = 1'b0;
        cycle(1, 8'h77);
        chk("abort_settle_bitslip", bitslip, 0);
        chk("abort_settle_slips", slip_count, 0);
        chk("abort_settle_data", rx_data_q, rx_data_out);
        chk("abort_settle_valid", rx_valid_q, 0);

        // train_en low, then reset, while locked.
        restart(0);
        lock_up("abort_lock_en");
        train_en = 1'b0;
        cycle(1, 8'h99);
        chk("abort_lock_aligned", aligned, 0);
        chk("abort_lock_valid", rx_valid_q, 0);
        chk("abort_lock_data", rx_data_q, 8'h99);
        restart(0);
        lock_up("abort_lock_rst");
        reset = 1'b1;
        cycle(1, 8'h99);
        chk("rst_lock_aligned", aligned, 0);
        chk("rst_lock_data", rx_data_q, 8'h00);
        reset = 1'b0;

        // Random soak: occasional resets, enable toggles, slow streams.
        vprob = 2;
        for (int k = 0; k < 3000; k++) begin
            if (k % 200 == 0) vprob = (k / 200) % 3 == 0 ? 2 : ((k / 200) % 3 == 1 ? 10 : 80);
            reset = ($urandom_range(0, 999) == 0);
            if ($urandom_range(0, 299) == 0) begin
                train_en = ~train_en;
                if (!train_en) rot = $urandom_range(0, 7);
            end
            if ($urandom_range(0, 49) == 0) train_en = 1'b1;
            cycle($urandom_range(0, vprob - 1) == 0,
                  ($urandom_range(0, 49) == 0) ? 8'($urandom) : Pat);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
